ifetch: RTL



---
 rtl/ifetch.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ifetch.sv
// ifetch: instruction fetch stage.
// Samples pc_curr, issues one read to instruction memory over imem_req/imem_ack,
// captures the returned word with its PC and holds it for the consumer on
// instr_valid/instr_ready. A flush abandons the current fetch. A request that
// is already on the bus is still held until its ack arrives (DRAIN), and the
// returned data is then dropped.
// Optional feature macro: IFETCH_TIMEOUT_EN. When it is defined, a watchdog
// ends a REQ/DRAIN that gets no ack and sets the sticky fetch_err flag.
module ifetch #(
  parameter int PC_W        = 10,
  parameter int INSTR_W     = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  input  logic               flush,
  input  logic [PC_W-1:0]    pc_curr,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               fetch_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               req_q, req_d;
  logic [PC_W-1:0]    addr_q, addr_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
  logic               timeout_hit;

`ifdef IFETCH_TIMEOUT_EN
  // The counter is at least 8 bits wide even for small limits.
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) < 8) ? 8 : $clog2(TIMEOUT_CYC + 1);
  // Timeout fires on the edge at which the count would reach TIMEOUT_CYC,
  // so the request is on the bus for exactly TIMEOUT_CYC cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign timeout_hit = (state_q == REQ || state_q == DRAIN) && !imem_ack &&
                       (cnt_q == CNT_LAST);

  // Watchdog count: clear on entry to REQ/DRAIN, count each waiting cycle there.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q | timeout_hit;
    if ((state_d == REQ || state_d == DRAIN) && state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == REQ || state_q == DRAIN) && !imem_ack) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Watchdog registers; fetch_err stays set until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign fetch_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign fetch_err   = 1'b0;
`endif

  // Next-state and next-output logic for the fetch FSM.
  // NOTE: every target gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    unique case (state_q)
      IDLE: begin
        // flush has priority over starting a fetch.
        if (fetch_en && !flush) begin
          req_d   = 1'b1;
          addr_d  = pc_curr;
          state_d = REQ;
        end
      end
      REQ: begin
        if (imem_ack) begin
          req_d = 1'b0;
          if (flush) begin
            state_d = IDLE;
          end else begin
            instr_d    = imem_rdata;
            instr_pc_d = addr_q;
            valid_d    = 1'b1;
            state_d    = HOLD;
          end
        end else if (timeout_hit) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end else if (flush) begin
          // The request must stay up until the memory acks it.
          state_d = DRAIN;
        end
      end
      HOLD: begin
        // Returning to IDLE inserts one bubble, so the PC update is visible before the next sample.
        if (instr_ready || flush) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (imem_ack || timeout_hit) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  // NOTE: non-blocking assignments here, so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      addr_q     <= '0;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

endmodule
